// File: rtl/systolic_pe.sv
// Output-stationary systolic-array processing element: one unsigned MAC per cycle
// plus registered operand forwarding. Define PE_SATURATE_EN to saturate instead of wrap.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_north,
    input  logic [DATA_W-1:0] in_west,
    output logic [DATA_W-1:0] out_south,
    output logic [DATA_W-1:0] out_east,
    output logic [ACC_W-1:0]  result
);

    localparam int PROD_W = 2 * DATA_W;

    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("systolic_pe: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic [PROD_W-1:0] product_s;
    logic [ACC_W-1:0]  product_ext_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic [ACC_W-1:0]  acc_r;
    logic [DATA_W-1:0] south_r;
    logic [DATA_W-1:0] east_r;

`ifdef PE_SATURATE_EN
    logic [ACC_W:0]    sum_s;

    // Full-width product and one-bit-wider sum so the carry flags overflow.
    always_comb begin
        product_s     = PROD_W'(in_north) * PROD_W'(in_west);
        product_ext_s = ACC_W'(product_s);
        sum_s         = {1'b0, acc_r} + {1'b0, product_ext_s};
        if (sum_s[ACC_W]) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
    end
`else
    // Full-width product; the accumulation wraps modulo 2^ACC_W.
    always_comb begin
        product_s     = PROD_W'(in_north) * PROD_W'(in_west);
        product_ext_s = ACC_W'(product_s);
        acc_next_s    = acc_r + product_ext_s;
    end
`endif

    // Accumulator and forwarding registers; reset is the only way to clear a tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {ACC_W{1'b0}};
            south_r <= {DATA_W{1'b0}};
            east_r  <= {DATA_W{1'b0}};
        end else begin
            acc_r   <= acc_next_s;
            south_r <= in_north;
            east_r  <= in_west;
        end
    end

    assign result    = acc_r;
    assign out_south = south_r;
    assign out_east  = east_r;

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: a default (ACC_W=32) and an ACC_W=16 instance share stimulus.
module tb_systolic_pe;

    typedef struct {
        logic [31:0] r32;
        logic [15:0] r16;
        logic [7:0]  s;
        logic [7:0]  e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_north = 8'd0;
    logic [7:0]  in_west  = 8'd0;
    logic [7:0]  south32, east32, south16, east16;
    logic [31:0] result32;
    logic [15:0] result16;

    int n_cmp = 0;
    int n_bad = 0;
    longint unsigned m32 = 0;
    longint unsigned m16 = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    systolic_pe #(.DATA_W(8), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_north(in_north), .in_west(in_west),
        .out_south(south32), .out_east(east32), .result(result32)
    );

    systolic_pe #(.DATA_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_north(in_north), .in_west(in_west),
        .out_south(south16), .out_east(east16), .result(result16)
    );

    function automatic longint unsigned acc_next(longint unsigned a, longint unsigned p, int w);
        longint unsigned mx = (64'd1 << w) - 64'd1;
        longint unsigned s  = a + p;
`ifdef PE_SATURATE_EN
        if (s > mx) return mx;
        return s;
`else
        return s & mx;
`endif
    endfunction

    task automatic drive(input logic [7:0] n, input logic [7:0] w);
        exp_t x;
        @(negedge clk);
        in_north = n;
        in_west  = w;
        m32 = acc_next(m32, longint'(n) * longint'(w), 32);
        m16 = acc_next(m16, longint'(n) * longint'(w), 16);
        x.r32 = m32[31:0];
        x.r16 = m16[15:0];
        x.s   = n;
        x.e   = w;
        q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m32 = 0;
        m16 = 0;
        @(negedge clk);
        in_north = 8'd0;
        in_west  = 8'd0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_north = 8'hAA;
        in_west  = 8'h55;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (result32 !== 32'd0 || south32 !== 8'd0 || east32 !== 8'd0 || result16 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_async: result=%0d south=%0h east=%0h r16=%0d, required all 0",
                     result32, south32, east32, result16);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (result32 !== 32'd0 || south32 !== 8'd0 || east32 !== 8'd0 || result16 !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: result=%0d south=%0h east=%0h r16=%0d, required all 0",
                         i, result32, south32, east32, result16);
            end
        end
        @(negedge clk);
        in_north = 8'd0;
        in_west  = 8'd0;
        rst = 1'b0;
    endtask

    task automatic test_basic_acc();
        logic [7:0] ns[3] = '{8'd2, 8'd4, 8'd1};
        logic [7:0] ws[3] = '{8'd3, 8'd5, 8'd6};
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            drive(ns[i], ws[i]);
            @(posedge clk); #1;
            x = q.pop_front();
            n_cmp++;
            if (result32 !== x.r32) begin
                n_bad++;
                $display("FAIL basic_acc[%0d]: result=%0d required=%0d", i, result32, x.r32);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [7:0] ns[3] = '{8'h12, 8'hFF, 8'h00};
        logic [7:0] ws[3] = '{8'h34, 8'h01, 8'hC3};
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            drive(ns[i], ws[i]);
            @(posedge clk); #1;
            x = q.pop_front();
            n_cmp++;
            if (south32 !== x.s || east32 !== x.e || south16 !== x.s || east16 !== x.e) begin
                n_bad++;
                $display("FAIL forward[%0d]: south=%0h east=%0h required south=%0h east=%0h",
                         i, south32, east32, x.s, x.e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ns[4] = '{8'd255, 8'd255, 8'd0, 8'd1};
        logic [7:0] ws[4] = '{8'd255, 8'd255, 8'd0, 8'd1};
`ifdef PE_SATURATE_EN
        logic [15:0] lit[4] = '{16'd65025, 16'd65535, 16'd65535, 16'd65535};
`else
        logic [15:0] lit[4] = '{16'd65025, 16'd64514, 16'd64514, 16'd64515};
`endif
        exp_t x;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(ns[i], ws[i]);
            @(posedge clk); #1;
            x = q.pop_front();
            n_cmp++;
            if (result16 !== x.r16 || result16 !== lit[i]) begin
                n_bad++;
                $display("FAIL overflow16[%0d]: result=%0d required=%0d", i, result16, lit[i]);
            end
            n_cmp++;
            if (result32 !== x.r32) begin
                n_bad++;
                $display("FAIL overflow32[%0d]: result=%0d required=%0d", i, result32, x.r32);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t x;
        do_reset();
        drive(8'd2, 8'd3);
        drive(8'd4, 8'd5);
        @(posedge clk); #1;
        x = q.pop_back();
        q.delete();
        n_cmp++;
        if (result32 !== x.r32 || result32 !== 32'd26) begin
            n_bad++;
            $display("FAIL mid_pre: result=%0d required=26", result32);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (result32 !== 32'd0 || south32 !== 8'd0 || east32 !== 8'd0 || result16 !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_async: result=%0d south=%0h east=%0h, required all 0",
                     result32, south32, east32);
        end
        m32 = 0;
        m16 = 0;
        #1;
        in_north = 8'd0;
        in_west  = 8'd0;
        rst = 1'b0;
        drive(8'd1, 8'd6);
        @(posedge clk); #1;
        x = q.pop_front();
        n_cmp++;
        if (result32 !== x.r32 || result32 !== 32'd6 || south32 !== 8'd1 || east32 !== 8'd6) begin
            n_bad++;
            $display("FAIL mid_post: result=%0d south=%0h east=%0h required result=6 south=1 east=6",
                     result32, south32, east32);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            @(posedge clk); #1;
            x = q.pop_front();
            n_cmp++;
            if (result32 !== x.r32 || result16 !== x.r16 || south32 !== x.s || east32 !== x.e) begin
                n_bad++;
                $display("FAIL b2b[%0d]: r32=%0d r16=%0d s=%0h e=%0h required r32=%0d r16=%0d s=%0h e=%0h",
                         i, result32, result16, south32, east32, x.r32, x.r16, x.s, x.e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_acc();
        test_forwarding();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
